// File: rtl/psram_arbiter_if.sv
// Bus bundle between the two requesters / PSRAM driver and the arbiter.
// The arbiter connects through the slave modport. The requester-and-driver
// side (or a bench standing in for it) uses the master modport.
interface psram_arbiter_if;
  // Requester port 0 (UART command path)
  logic        req0;
  logic [1:0]  rw0;
  logic [22:0] addr0;
  logic [15:0] wdata0;
  logic        ack0;
  logic        done0;
  logic [15:0] rdata0;
  logic        err0;

  // Requester port 1 (capture/stream path)
  logic        req1;
  logic [1:0]  rw1;
  logic [22:0] addr1;
  logic [15:0] wdata1;
  logic        ack1;
  logic        done1;
  logic [15:0] rdata1;
  logic        err1;

  // PSRAM driver side
  logic        qpi_on;
  logic        endcommand;
  logic [15:0] data_out;
  logic        quad_start;
  logic [1:0]  read_write;
  logic [22:0] address;
  logic [15:0] data_in;

  // Status
  logic        busy;

  modport slave (
    input  req0, rw0, addr0, wdata0,
    input  req1, rw1, addr1, wdata1,
    input  qpi_on, endcommand, data_out,
    output ack0, done0, rdata0, err0,
    output ack1, done1, rdata1, err1,
    output quad_start, read_write, address, data_in, busy
  );

  modport master (
    output req0, rw0, addr0, wdata0,
    output req1, rw1, addr1, wdata1,
    output qpi_on, endcommand, data_out,
    input  ack0, done0, rdata0, err0,
    input  ack1, done1, rdata1, err1,
    input  quad_start, read_write, address, data_in, busy
  );
endinterface

// File: rtl/psram_arbiter.sv
// Two-port round-robin arbiter and single-transaction sequencer in front of
// the QPI PSRAM driver. It waits for driver bring-up, grants one 16-bit
// read/write at a time, and issues it with one quad_start pulse. It then
// waits for endcommand (bounded by TIMEOUT), returns read data, and enforces
// a CE-high recovery gap before the next issue.
module psram_arbiter #(
  parameter int TIMEOUT    = 64,
  parameter int GAP_CYCLES = 2
) (
  input logic            mem_clk,
  input logic            rst_n,
  psram_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_IDLE  = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4,
    S_GAP   = 3'd5
  } state_t;

  // One counter is shared by INIT (qpi_on qualification), WAIT (timeout)
  // and GAP (recovery). It must hold both TIMEOUT and GAP_CYCLES (max 15).
  localparam int CW = $clog2(TIMEOUT + 16);

  localparam logic [CW-1:0] CNT_ONE     = CW'(1);
  localparam logic [CW-1:0] TIMEOUT_END = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] GAP_END     = CW'(GAP_CYCLES - 1);

  // Internal reset: asserts asynchronously and releases on a clock edge.
  logic [1:0] rst_sync_q;
  logic       rst_int_n;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q;

  logic          last_grant_q;
  logic          win_q;
  logic [1:0]    rw_q;
  logic [22:0]   addr_q;
  logic [15:0]   wdata_q;
  logic [15:0]   rdata0_q, rdata1_q;
  logic          err_q;

  logic          any_req;
  logic          pick;
  logic          rw_valid;
  logic          ec_ok;
  logic          grant;

  logic          quad_start_o;
  logic          ack0_o, ack1_o;
  logic          done0_o, done1_o;
  logic          err0_o, err1_o;

  // The reset synchronizer: assert at once, release after two clean edges.
  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_int_n = rst_sync_q[1];

  // Winner: the single requester, or on a tie the port not granted last time.
  assign any_req  = bus.req0 | bus.req1;
  assign pick     = (bus.req0 & bus.req1) ? ~last_grant_q : ~bus.req0;
  assign rw_valid = (rw_q == 2'd1) || (rw_q == 2'd2);
  // endcommand counts only from the second WAIT cycle, because the driver
  // flag changes on the falling edge and may still be stale in the first one.
  assign ec_ok    = (state_q == S_WAIT) && (cnt_q != '0) && bus.endcommand;
  assign grant    = (state_q == S_IDLE) && bus.qpi_on && any_req;

  // State register, shared counter and registered busy flag.
  always_ff @(posedge mem_clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d != S_IDLE);
    end
  end

  // Next-state and counter logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_INIT: begin
        if (bus.qpi_on) begin
          if (cnt_q != '0) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else begin
          cnt_d = '0;
        end
      end
      S_IDLE: begin
        cnt_d = '0;
        if (!bus.qpi_on) begin
          state_d = S_INIT;
        end else if (any_req) begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = rw_valid ? S_WAIT : S_DONE;
      end
      S_WAIT: begin
        if (ec_ok || (cnt_q == TIMEOUT_END)) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_DONE: begin
        cnt_d   = '0;
        state_d = S_GAP;
      end
      S_GAP: begin
        if (cnt_q == GAP_END) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = S_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  // Datapath: capture the winner's fields, record the error and latch read data.
  always_ff @(posedge mem_clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      last_grant_q <= 1'b1;
      win_q        <= 1'b0;
      rw_q         <= 2'd0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      err_q        <= 1'b0;
    end else begin
      if (grant) begin
        win_q        <= pick;
        last_grant_q <= pick;
        rw_q         <= pick ? bus.rw1    : bus.rw0;
        addr_q       <= pick ? bus.addr1  : bus.addr0;
        wdata_q      <= pick ? bus.wdata1 : bus.wdata0;
      end
      if (state_q == S_ISSUE) begin
        err_q <= ~rw_valid;
      end
      if ((state_q == S_WAIT) && (state_d == S_DONE)) begin
        err_q <= ~ec_ok;
      end
      // data_out is sampled alongside endcommand so rdata is ready during DONE.
      if (ec_ok && (rw_q == 2'd2)) begin
        if (win_q) begin
          rdata1_q <= bus.data_out;
        end else begin
          rdata0_q <= bus.data_out;
        end
      end
    end
  end

  // Per-state pulse outputs decoded from the current state and the winner.
  always_comb begin
    quad_start_o = 1'b0;
    ack0_o       = 1'b0;
    ack1_o       = 1'b0;
    done0_o      = 1'b0;
    done1_o      = 1'b0;
    err0_o       = 1'b0;
    err1_o       = 1'b0;
    if (state_q == S_ISSUE) begin
      quad_start_o = rw_valid;
      ack0_o       = ~win_q;
      ack1_o       = win_q;
    end
    if (state_q == S_DONE) begin
      done0_o = ~win_q;
      done1_o = win_q;
      err0_o  = ~win_q & err_q;
      err1_o  = win_q & err_q;
    end
  end

  assign bus.quad_start = quad_start_o;
  assign bus.ack0       = ack0_o;
  assign bus.ack1       = ack1_o;
  assign bus.done0      = done0_o;
  assign bus.done1      = done1_o;
  assign bus.err0       = err0_o;
  assign bus.err1       = err1_o;
  assign bus.rdata0     = rdata0_q;
  assign bus.rdata1     = rdata1_q;
  assign bus.read_write = rw_q;
  assign bus.address    = addr_q;
  assign bus.data_in    = wdata_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_psram_arbiter.sv
// Bench for psram_arbiter: directed requests with hand-computed results,
// a simple PSRAM driver model, and a scoreboard monitor checking every
// ack/quad_start/done the arbiter presents.
module tb_psram_arbiter;
  localparam int TIMEOUT = 64;
  localparam int GAP     = 2;

  logic mem_clk = 1'b0;
  logic rst_n   = 1'b0;

  psram_arbiter_if bus();

  psram_arbiter #(.TIMEOUT(TIMEOUT), .GAP_CYCLES(GAP)) dut (
    .mem_clk (mem_clk),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  always #5 mem_clk = ~mem_clk;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  always @(posedge mem_clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0]  rw;
    logic [22:0] addr;
    logic [15:0] wdata;
    logic        exp_qs;
    logic        exp_err;
    logic [15:0] exp_rdata;
    int          exp_lat;
  } req_t;

  req_t exp_q0[$];
  req_t exp_q1[$];
  req_t cur;
  bit   in_flight = 0;
  int   cur_port  = 0;
  int   issue_cyc = 0;
  bit   have_done = 0;
  int   last_done_cyc = 0;
  bit   prev_qs   = 0;
  bit   log_grants = 0;
  int   grant_log[$];

  // Driver model controls
  int   ec_delay = 14;
  bit   ec_never = 0;
  logic [15:0] mem [logic [22:0]];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input string msg);
    tests_run++;
    tests_failed++;
    $display("FAIL %s: %s", name, msg);
  endtask

  task automatic check_zero(input string name);
    check({name, "_pulses"}, {bus.ack0, bus.ack1, bus.done0, bus.done1,
                              bus.err0, bus.err1, bus.quad_start, bus.busy}, 0);
    check({name, "_rdata0"}, bus.rdata0, 0);
    check({name, "_rdata1"}, bus.rdata1, 0);
    check({name, "_rw"},     bus.read_write, 0);
    check({name, "_addr"},   bus.address, 0);
    check({name, "_din"},    bus.data_in, 0);
  endtask

  // PSRAM driver model: after each start, raise endcommand for one cycle
  // ec_delay cycles later, serving reads from / storing writes into mem.
  initial begin
    logic [1:0]  d_rw;
    logic [22:0] d_a;
    logic [15:0] d_wd;
    bus.endcommand = 1'b0;
    bus.data_out   = 16'h0;
    forever begin
      @(negedge mem_clk);
      if (rst_n && bus.quad_start) begin
        d_rw = bus.read_write;
        d_a  = bus.address;
        d_wd = bus.data_in;
        if (!ec_never) begin
          repeat (ec_delay) @(negedge mem_clk);
          if (d_rw == 2'd2) bus.data_out = mem.exists(d_a) ? mem[d_a] : 16'h0;
          else              mem[d_a] = d_wd;
          bus.endcommand = 1'b1;
          @(negedge mem_clk);
          bus.endcommand = 1'b0;
        end
      end
    end
  end

  // Scoreboard monitor: pops the expected entry on ack, then checks the
  // held fields each cycle and the result on done.
  initial begin
    int   p;
    req_t e;
    forever begin
      @(negedge mem_clk);
      if (!rst_n) begin
        in_flight = 0;
        have_done = 0;
        prev_qs   = 0;
      end else begin
        if (bus.ack0 || bus.ack1) check("ack_exclusive", {31'd0, bus.ack0 & bus.ack1}, 0);
        if (bus.done0 || bus.done1) check("done_exclusive", {31'd0, bus.done0 & bus.done1}, 0);
        if (bus.quad_start) begin
          check("qs_back_to_back", {31'd0, prev_qs}, 0);
          if (have_done) check("qs_after_gap", {31'd0, (cyc - last_done_cyc) >= GAP + 2}, 1);
        end
        prev_qs = bus.quad_start;

        if (in_flight) begin
          check("hold_rw",   bus.read_write, cur.rw);
          check("hold_addr", bus.address,    cur.addr);
          check("hold_din",  bus.data_in,    cur.wdata);
        end

        if (bus.ack0 || bus.ack1) begin
          p = bus.ack1 ? 1 : 0;
          if ((p == 0 && exp_q0.size() == 0) || (p == 1 && exp_q1.size() == 0)) begin
            fail("ack_unexpected", $sformatf("port %0d acked with nothing pending", p));
          end else begin
            e = (p == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            check("issue_qs",   {31'd0, bus.quad_start}, {31'd0, e.exp_qs});
            check("issue_rw",   bus.read_write, e.rw);
            check("issue_addr", bus.address,    e.addr);
            check("issue_din",  bus.data_in,    e.wdata);
            cur       = e;
            cur_port  = p;
            in_flight = 1;
            issue_cyc = cyc;
            if (log_grants) grant_log.push_back(p);
          end
        end

        if (bus.done0 || bus.done1) begin
          p = bus.done1 ? 1 : 0;
          if (!in_flight) begin
            fail("done_unexpected", $sformatf("done on port %0d with nothing in flight", p));
          end else begin
            check("done_port", p, cur_port);
            check("done_err",  {31'd0, (p == 1) ? bus.err1 : bus.err0}, {31'd0, cur.exp_err});
            check("done_rdata", (p == 1) ? bus.rdata1 : bus.rdata0, cur.exp_rdata);
            if (cur.exp_lat != 0) check("done_latency", cyc - issue_cyc, cur.exp_lat);
            in_flight     = 0;
            have_done     = 1;
            last_done_cyc = cyc;
          end
        end
      end
    end
  end

  // Present one request on port p, queue its expected outcome and wait for ack.
  task automatic do_req(input int p, input logic [1:0] rw, input logic [22:0] a,
                        input logic [15:0] wd, input logic exp_err,
                        input logic [15:0] exp_rd, input int lat, input bit keep);
    req_t e;
    bit   got;
    e.rw        = rw;
    e.addr      = a;
    e.wdata     = wd;
    e.exp_qs    = (rw == 2'd1) || (rw == 2'd2);
    e.exp_err   = exp_err;
    e.exp_rdata = exp_rd;
    e.exp_lat   = lat;
    got         = 0;
    if (p == 0) begin
      bus.rw0 = rw; bus.addr0 = a; bus.wdata0 = wd; bus.req0 = 1'b1;
      exp_q0.push_back(e);
    end else begin
      bus.rw1 = rw; bus.addr1 = a; bus.wdata1 = wd; bus.req1 = 1'b1;
      exp_q1.push_back(e);
    end
    for (int i = 0; i < 400; i++) begin
      @(negedge mem_clk);
      if ((p == 0 && bus.ack0) || (p == 1 && bus.ack1)) begin
        got = 1;
        break;
      end
    end
    if (!got) fail("ack_timeout", $sformatf("port %0d never acked", p));
    if (!keep) begin
      if (p == 0) bus.req0 = 1'b0;
      else        bus.req1 = 1'b0;
    end
  endtask

  // Wait until nothing is pending and the arbiter is back in IDLE.
  task automatic wait_idle(input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge mem_clk);
      if (!in_flight && !bus.busy && exp_q0.size() == 0 && exp_q1.size() == 0) begin
        ok = 1;
        break;
      end
    end
    if (!ok) fail(name, "arbiter did not return to idle");
  endtask

  int exp_order [6] = '{0, 1, 0, 1, 0, 1};

  initial begin
    bus.req0 = 1'b0; bus.rw0 = 2'd0; bus.addr0 = '0; bus.wdata0 = '0;
    bus.req1 = 1'b0; bus.rw1 = 2'd0; bus.addr1 = '0; bus.wdata1 = '0;
    bus.qpi_on = 1'b0;

    // Reset values, then INIT held while qpi_on is low.
    repeat (3) @(negedge mem_clk);
    check_zero("reset");
    rst_n = 1'b1;
    repeat (4) @(negedge mem_clk);
    for (int i = 0; i < 100; i++) begin
      @(negedge mem_clk);
      check("init_busy", {31'd0, bus.busy}, 1);
      check("init_no_qs", {31'd0, bus.quad_start}, 0);
    end
    bus.qpi_on = 1'b1;
    @(negedge mem_clk);
    check("init_busy_1cyc", {31'd0, bus.busy}, 1);
    @(negedge mem_clk);
    check("idle_after_2cyc", {31'd0, bus.busy}, 0);

    // Port 0 write, endcommand 14 cycles after start; rdata0 untouched.
    ec_delay = 14;
    do_req(0, 2'd1, 23'h000010, 16'hA5C3, 1'b0, 16'h0000, 15, 0);
    wait_idle("idle_after_write");

    // Port 1 read of the same word.
    do_req(1, 2'd2, 23'h000010, 16'h0000, 1'b0, 16'hA5C3, 15, 0);
    wait_idle("idle_after_read");

    // Driver never completes: timeout error exactly TIMEOUT+1 cycles after issue.
    ec_never = 1;
    do_req(0, 2'd2, 23'h000020, 16'h0000, 1'b1, 16'h0000, TIMEOUT + 1, 0);
    wait_idle("idle_after_timeout");
    ec_never = 0;
    ec_delay = 3;
    do_req(0, 2'd2, 23'h000010, 16'h0000, 1'b0, 16'hA5C3, 4, 0);
    wait_idle("idle_after_recovery");

    // Invalid rw: ack and error done next cycle, no quad_start, rdata kept.
    do_req(0, 2'd3, 23'h000077, 16'hFFFF, 1'b1, 16'hA5C3, 1, 0);
    wait_idle("idle_after_invalid");

    // Fastest driver response: done four cycles after the request edge.
    ec_delay = 2;
    do_req(1, 2'd1, 23'h000030, 16'h1234, 1'b0, 16'hA5C3, 3, 0);
    wait_idle("idle_after_fast_write");
    do_req(0, 2'd2, 23'h000030, 16'h0000, 1'b0, 16'h1234, 3, 0);
    wait_idle("idle_after_fast_read");

    // Reset pulsed during WAIT: outputs clear at once, no done afterwards.
    ec_never = 1;
    do_req(1, 2'd2, 23'h000010, 16'h0000, 1'b0, 16'h0000, 0, 0);
    repeat (3) @(negedge mem_clk);
    #2 rst_n = 1'b0;
    #1 check_zero("mid_reset");
    bus.qpi_on = 1'b0;
    @(negedge mem_clk);
    rst_n = 1'b1;
    repeat (5) @(negedge mem_clk);
    check("post_reset_init_busy", {31'd0, bus.busy}, 1);
    check("post_reset_rdata1", bus.rdata1, 0);
    bus.qpi_on = 1'b1;
    ec_never   = 0;
    wait_idle("idle_after_reset");

    // From reset, both ports request back to back: grants alternate 0,1,...
    rst_n = 1'b0;
    @(negedge mem_clk);
    rst_n = 1'b1;
    repeat (4) @(negedge mem_clk);
    wait_idle("idle_before_rr");
    ec_delay   = 5;
    log_grants = 1;
    grant_log.delete();
    fork
      begin
        do_req(0, 2'd1, 23'h000040, 16'h1111, 1'b0, 16'h0000, 6, 1);
        do_req(0, 2'd1, 23'h000041, 16'h2222, 1'b0, 16'h0000, 6, 1);
        do_req(0, 2'd2, 23'h000040, 16'h0000, 1'b0, 16'h1111, 6, 0);
      end
      begin
        do_req(1, 2'd1, 23'h000050, 16'hBEEF, 1'b0, 16'h0000, 6, 1);
        do_req(1, 2'd2, 23'h000050, 16'h0000, 1'b0, 16'hBEEF, 6, 1);
        do_req(1, 2'd2, 23'h000041, 16'h0000, 1'b0, 16'h2222, 6, 0);
      end
    join
    wait_idle("idle_after_rr");
    log_grants = 0;
    check("rr_grant_count", grant_log.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < grant_log.size()) check($sformatf("rr_grant_%0d", i), grant_log[i], exp_order[i]);
    end

    repeat (5) @(negedge mem_clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
